// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the sequential BCD calculator:
//   - state_t  : controller states
//   - opcode_t : latched arithmetic operation
//   - SEG_*    : active-low 7-segment patterns for the special glyphs
//   - nbcd()   : number of BCD digits needed for an unsigned value of a
//                given bit width
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    MUL  = 3'd2,
    CONV = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } opcode_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Decimal digit count of the largest res_w-bit value (2^res_w - 1).
  // This equals ceil(res_w*log10(2)) because 2^n is never a power of ten.
  function automatic int nbcd(input int res_w);
    longint unsigned v;
    int              n;
    v = (64'd1 << res_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// ---------------------------------------------------------------------------
// seg7_dec
// 4-bit BCD to active-low 7-segment decoder (segment order g..a, MSB = g).
// Codes above 9 decode to a blank digit.
//   i_bcd : BCD digit value
//   o_seg : active-low segment pattern
// ---------------------------------------------------------------------------
module seg7_dec
  import calc_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_bcd_seq.sv
// ---------------------------------------------------------------------------
// calc_bcd_seq
// Sequential switch calculator. A key press latches A = SW[2*OP_W-1:OP_W]
// and B = SW[OP_W-1:0], performs add / signed-magnitude subtract / shift-add
// multiply, converts the magnitude to BCD with a bit-serial double-dabble
// and shows it on DIGITS active-low 7-segment displays.
//
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high reset
//   SW       : operands (A upper half, B lower half)
//   KEY      : active-low buttons, 0 add, 1 sub, 2 mul, 3 clear
//   LEDR     : binary result magnitude
//   neg      : result is negative
//   ovf      : result does not fit on the display
//   busy     : operation in progress
//   HEX      : active-low segments, digit i on HEX[7*i+6:7*i]
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros and
// place the minus sign just left of the most significant digit. Without it
// every digit shows a value and the minus sign sits on the top digit.
// ---------------------------------------------------------------------------
module calc_bcd_seq
  import calc_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [2*OP_W-1:0]     SW,
  input  logic [3:0]            KEY,
  output logic [2*OP_W-1:0]     LEDR,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int RES_W = 2 * OP_W;
  localparam int NBCD  = nbcd(RES_W);
  localparam int CNT_W = $clog2(RES_W + 1);

  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(RES_W - 1);

  localparam logic [7*DIGITS-1:0] HEX_RESET = {{(7*(DIGITS-1)){1'b1}}, SEG_ZERO};
  localparam logic [7*DIGITS-1:0] HEX_ERR   = {{(7*(DIGITS-1)){1'b1}}, SEG_E};

  // key path
  logic [3:0]        r_key_s1;
  logic [3:0]        r_key_s2;
  logic [3:0]        r_key_prev;
  logic [3:0]        w_press;
  logic              w_clear;
  logic              w_start;
  opcode_t           w_op_sel;

  // control / datapath
  state_t            r_state;
  state_t            w_state_next;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  opcode_t           r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [RES_W-1:0]  r_mag;
  logic [RES_W-1:0]  r_mcand;
  logic [OP_W-1:0]   r_mplier;
  logic              r_sign;
  logic [RES_W-1:0]  r_bin;
  logic [4*NBCD-1:0] r_bcd;

  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [RES_W-1:0]  w_calc_mag;
  logic              w_calc_neg;
  logic [RES_W-1:0]  w_mul_acc;
  logic [4*NBCD-1:0] w_bcd_adj;
  logic [4*NBCD-1:0] w_bcd_shift;

  // display
  logic [3:0]           w_dig [DIGITS];
  logic [6:0]           w_seg [DIGITS];
  int                   w_nd;
  logic                 w_ovf;
  logic [7*DIGITS-1:0]  w_hex_val;
  logic [7*DIGITS-1:0]  w_hex;

  // registered outputs
  logic [RES_W-1:0]     r_ledr;
  logic                 r_neg;
  logic                 r_ovf;
  logic                 r_busy;
  logic [7*DIGITS-1:0]  r_hex;

  // ------------------------------------------------------------------------
  // Key input path
  // ------------------------------------------------------------------------

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_key_s1   <= 4'hF;
      r_key_s2   <= 4'hF;
      r_key_prev <= 4'hF;
    end else begin
      r_key_s1   <= KEY;
      r_key_s2   <= r_key_s1;
      r_key_prev <= r_key_s2;
    end
  end

  // A press is the synchronised level going 1 -> 0
  assign w_press = r_key_prev & ~r_key_s2;
  assign w_clear = w_press[3];
  assign w_start = |w_press[2:0];

  // Opcode priority KEY0 > KEY1 > KEY2 (KEY3 is handled ahead of this)
  always_comb begin
    w_op_sel = OP_ADD;
    if (w_press[0]) begin
      w_op_sel = OP_ADD;
    end else if (w_press[1]) begin
      w_op_sel = OP_SUB;
    end else if (w_press[2]) begin
      w_op_sel = OP_MUL;
    end else begin
      w_op_sel = OP_ADD;
    end
  end

  // ------------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------------

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    w_state_next = r_state;
    if (w_clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_state_next = (w_op_sel == OP_MUL) ? MUL : CALC;
          end else begin
            w_state_next = IDLE;
          end
        end
        CALC: w_state_next = CONV;
        MUL: begin
          if (r_cnt == MUL_LAST) begin
            w_state_next = CONV;
          end else begin
            w_state_next = MUL;
          end
        end
        CONV: begin
          if (r_cnt == CONV_LAST) begin
            w_state_next = DONE;
          end else begin
            w_state_next = CONV;
          end
        end
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Arithmetic
  // ------------------------------------------------------------------------

  assign w_a_ext = {{OP_W{1'b0}}, r_a};
  assign w_b_ext = {{OP_W{1'b0}}, r_b};

  // Add, or subtract as sign + magnitude
  always_comb begin
    w_calc_mag = w_a_ext + w_b_ext;
    w_calc_neg = 1'b0;
    if (r_op == OP_SUB) begin
      if (r_a < r_b) begin
        w_calc_mag = w_b_ext - w_a_ext;
        w_calc_neg = 1'b1;
      end else begin
        w_calc_mag = w_a_ext - w_b_ext;
        w_calc_neg = 1'b0;
      end
    end else begin
      w_calc_mag = w_a_ext + w_b_ext;
      w_calc_neg = 1'b0;
    end
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set
  assign w_mul_acc = r_mplier[0] ? (r_mag + r_mcand) : r_mag;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NBCD; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
  end

  assign w_bcd_shift = {w_bcd_adj[4*NBCD-2:0], r_bin[RES_W-1]};

  // Datapath registers: operand latch, multiply, BCD conversion
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_clear) begin
      r_a      <= {OP_W{1'b0}};
      r_b      <= {OP_W{1'b0}};
      r_op     <= OP_ADD;
      r_cnt    <= {CNT_W{1'b0}};
      r_mag    <= {RES_W{1'b0}};
      r_mcand  <= {RES_W{1'b0}};
      r_mplier <= {OP_W{1'b0}};
      r_sign   <= 1'b0;
      r_bin    <= {RES_W{1'b0}};
      r_bcd    <= {(4*NBCD){1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_a      <= SW[2*OP_W-1:OP_W];
            r_b      <= SW[OP_W-1:0];
            r_op     <= w_op_sel;
            r_cnt    <= {CNT_W{1'b0}};
            r_mag    <= {RES_W{1'b0}};
            r_mcand  <= {{OP_W{1'b0}}, SW[2*OP_W-1:OP_W]};
            r_mplier <= SW[OP_W-1:0];
            r_sign   <= 1'b0;
          end
        end
        CALC: begin
          r_mag  <= w_calc_mag;
          r_sign <= w_calc_neg;
          r_bin  <= w_calc_mag;
          r_bcd  <= {(4*NBCD){1'b0}};
          r_cnt  <= {CNT_W{1'b0}};
        end
        MUL: begin
          r_mag    <= w_mul_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == MUL_LAST) begin
            // Hand the final product straight to the converter
            r_bin <= w_mul_acc;
            r_bcd <= {(4*NBCD){1'b0}};
            r_cnt <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        CONV: begin
          r_bin <= r_bin << 1;
          r_bcd <= w_bcd_shift;
          if (r_cnt == CONV_LAST) begin
            r_cnt <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Display formatting
  // ------------------------------------------------------------------------

  // Decoder inputs; digits beyond the BCD register width read as zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g < NBCD) begin : g_live
      assign w_dig[g] = r_bcd[4*g +: 4];
    end else begin : g_pad
      assign w_dig[g] = 4'd0;
    end
    seg7_dec u_seg7_dec (
      .i_bcd (w_dig[g]),
      .o_seg (w_seg[g])
    );
  end

  // Number of significant digits (at least one, so zero shows as '0')
  always_comb begin
    w_nd = 1;
    for (int i = 0; i < NBCD; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        w_nd = i + 1;
      end else begin
        w_nd = w_nd;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Significant digits only; minus sign immediately left of them
  always_comb begin
    w_ovf     = (w_nd + (r_sign ? 1 : 0)) > DIGITS;
    w_hex_val = {(7*DIGITS){1'b1}};
    for (int g = 0; g < DIGITS; g++) begin
      if (g < w_nd) begin
        w_hex_val[7*g +: 7] = w_seg[g];
      end else if ((g == w_nd) && r_sign) begin
        w_hex_val[7*g +: 7] = SEG_MINUS;
      end else begin
        w_hex_val[7*g +: 7] = SEG_BLANK;
      end
    end
  end
`else
  // Fixed-width display; the top digit is given up to the minus sign
  always_comb begin
    w_ovf     = 1'b0;
    w_hex_val = {(7*DIGITS){1'b1}};
    for (int i = 0; i < NBCD; i++) begin
      if ((r_bcd[4*i +: 4] != 4'd0) &&
          ((i >= DIGITS) || (r_sign && (i >= DIGITS - 1)))) begin
        w_ovf = 1'b1;
      end else begin
        w_ovf = w_ovf;
      end
    end
    for (int g = 0; g < DIGITS; g++) begin
      if (r_sign && (g == DIGITS - 1)) begin
        w_hex_val[7*g +: 7] = SEG_MINUS;
      end else begin
        w_hex_val[7*g +: 7] = w_seg[g];
      end
    end
  end
`endif

  assign w_hex = w_ovf ? HEX_ERR : w_hex_val;

  // Output registers, loaded once per operation in DONE
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_clear) begin
      r_ledr <= {RES_W{1'b0}};
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_hex  <= HEX_RESET;
    end else begin
      r_busy <= (w_state_next != IDLE);
      if (r_state == DONE) begin
        r_ledr <= r_mag;
        r_neg  <= r_sign;
        r_ovf  <= w_ovf;
        r_hex  <= w_hex;
      end
    end
  end

  assign LEDR = r_ledr;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign HEX  = r_hex;

endmodule
